// File: rtl/bsg_clk_gen_pearl_freq_checker_if.sv
// Control, monitor and result bundle for bsg_clk_gen_pearl_freq_checker.
// The harness drives through the master modport and the checker sits on the slave modport.
interface bsg_clk_gen_pearl_freq_checker_if
  #(parameter int num_channels_p = 2
   ,parameter int count_width_p  = 16);

  logic                                    start_i;
  logic [num_channels_p-1:0]               mon_i;
  logic [num_channels_p*count_width_p-1:0] expected_min_i;
  logic [num_channels_p*count_width_p-1:0] expected_max_i;
  logic                                    busy_o;
  logic                                    done_o;
  logic [num_channels_p*count_width_p-1:0] count_o;
  logic [num_channels_p-1:0]               overflow_o;
  logic [num_channels_p-1:0]               pass_o;
  logic                                    all_pass_o;

  modport master (output start_i, mon_i, expected_min_i, expected_max_i
                 ,input  busy_o, done_o, count_o, overflow_o, pass_o, all_pass_o);

  modport slave  (input  start_i, mon_i, expected_min_i, expected_max_i
                 ,output busy_o, done_o, count_o, overflow_o, pass_o, all_pass_o);

endinterface

// File: rtl/bsg_clk_gen_pearl_freq_checker.sv
// Counts synchronized rising edges per channel over a fixed window and range-checks each count.
// Define BSG_CLK_GEN_PEARL_FREQ_CHECKER_CONTINUOUS_EN for back-to-back windows after the first start.
module bsg_clk_gen_pearl_freq_checker
  #(parameter int num_channels_p  = 2
   ,parameter int window_cycles_p = 1024
   ,parameter int count_width_p   = 16
   ,parameter int sync_stages_p   = 2)
  (input  logic clk_i
  ,input  logic reset_i
  ,bsg_clk_gen_pearl_freq_checker_if.slave chk_if);

  localparam int win_width_lp    = (window_cycles_p + 1 == 1) ? 1 : $clog2(window_cycles_p + 1);
  localparam int settle_width_lp = $clog2(sync_stages_p + 1);
  localparam logic [count_width_p-1:0] count_max_lp = '1;

  typedef enum logic [1:0] {e_idle, e_settle, e_measure, e_report} state_e;

  state_e                                        state_q, state_d;
  logic [settle_width_lp-1:0]                    settle_cnt_q, settle_cnt_d;
  logic [win_width_lp-1:0]                       win_cnt_q, win_cnt_d;
  logic [sync_stages_p-1:0][num_channels_p-1:0]  sync_q, sync_d;
  logic [num_channels_p-1:0]                     prev_q, prev_d, rise_w;
  logic [num_channels_p-1:0][count_width_p-1:0]  cnt_q, cnt_d, count_q, count_d;
  logic [num_channels_p-1:0][count_width_p-1:0]  min_w, max_w;
  logic [num_channels_p-1:0]                     ovf_q, ovf_d, overflow_q, overflow_d;
  logic [num_channels_p-1:0]                     pass_q, pass_d;
  logic                                          busy_q, busy_d, done_q, done_d;
  logic                                          all_pass_q, all_pass_d;

  assign min_w = chk_if.expected_min_i;
  assign max_w = chk_if.expected_max_i;

  // Front end: stage 0 sees the raw asynchronous input, prev_q holds the last synchronized value.
  always_comb begin
    sync_d = {sync_q[sync_stages_p-2:0], chk_if.mon_i};
    prev_d = sync_q[sync_stages_p-1];
    rise_w = sync_q[sync_stages_p-1] & ~prev_q;
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    pass_d       = pass_q;
    all_pass_d   = all_pass_q;
    done_d       = 1'b0;

    unique case (state_q)
      e_idle: begin
        if (chk_if.start_i) begin
          state_d      = e_settle;
          settle_cnt_d = '0;
          cnt_d        = '0;
          ovf_d        = '0;
        end
      end

      e_settle: begin
        if (settle_cnt_q == settle_width_lp'(sync_stages_p)) begin
          state_d   = e_measure;
          win_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + settle_width_lp'(1);
        end
      end

      e_measure: begin
        for (int k = 0; k < num_channels_p; k++) begin
          if (rise_w[k]) begin
            if (cnt_q[k] == count_max_lp) ovf_d[k] = 1'b1;
            else                          cnt_d[k] = cnt_q[k] + count_width_p'(1);
          end
        end
        if (win_cnt_q == win_width_lp'(window_cycles_p - 1)) state_d   = e_report;
        else                                                 win_cnt_d = win_cnt_q + win_width_lp'(1);
      end

      e_report: begin
        done_d     = 1'b1;
        count_d    = cnt_q;
        overflow_d = ovf_q;
        for (int k = 0; k < num_channels_p; k++) begin
          pass_d[k] = ~ovf_q[k] & (min_w[k] <= cnt_q[k]) & (cnt_q[k] <= max_w[k]);
        end
        all_pass_d = &pass_d;
`ifdef BSG_CLK_GEN_PEARL_FREQ_CHECKER_CONTINUOUS_EN
        // Synchronizers are already settled, so the next window starts immediately.
        state_d   = e_measure;
        win_cnt_d = '0;
        cnt_d     = '0;
        ovf_d     = '0;
`else
        state_d   = e_idle;
`endif
      end

      default: state_d = e_idle;
    endcase

    // Busy stays high through the cycle that presents done_o.
    busy_d = (state_d != e_idle) | (state_q == e_report);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_idle;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      sync_q       <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      ovf_q        <= '0;
      count_q      <= '0;
      overflow_q   <= '0;
      pass_q       <= '0;
      all_pass_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      pass_q       <= pass_d;
      all_pass_q   <= all_pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign chk_if.busy_o     = busy_q;
  assign chk_if.done_o     = done_q;
  assign chk_if.count_o    = count_q;
  assign chk_if.overflow_o = overflow_q;
  assign chk_if.pass_o     = pass_q;
  assign chk_if.all_pass_o = all_pass_q;

endmodule

// File: tb/tb_bsg_clk_gen_pearl_freq_checker.sv
// Directed and randomized checks of bsg_clk_gen_pearl_freq_checker against a sample-history edge model.
// Define BSG_CLK_GEN_PEARL_FREQ_CHECKER_CONTINUOUS_EN to exercise the free-running build instead.
module tb_bsg_clk_gen_pearl_freq_checker;

  localparam int nc_lp   = 2;
  localparam int win_lp  = 64;
  localparam int cw_lp   = 4;
  localparam int ss_lp   = 2;
  localparam int lat_lp  = ss_lp + 2 + win_lp;
  localparam int cmax_lp = (1 << cw_lp) - 1;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  bsg_clk_gen_pearl_freq_checker_if #(.num_channels_p(nc_lp), .count_width_p(cw_lp)) bus ();

  bsg_clk_gen_pearl_freq_checker
    #(.num_channels_p(nc_lp), .window_cycles_p(win_lp), .count_width_p(cw_lp), .sync_stages_p(ss_lp))
  dut (.clk_i(clk_i), .reset_i(reset_i), .chk_if(bus));

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int last_edge = 0;
  logic [nc_lp-1:0] hist [0:8191];
  logic [nc_lp-1:0] mon_v = '0;
  int hp [nc_lp];
  int ph [nc_lp];
  int mn [nc_lp];
  int mx [nc_lp];
  logic [nc_lp*cw_lp-1:0] held_count = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: log the value each channel presented at this edge, then advance the toggle generators.
  task automatic step();
    @(posedge clk_i);
    hist[cyc] = bus.mon_i;
    last_edge = cyc;
    cyc++;
    #1;
    for (int k = 0; k < nc_lp; k++) begin
      if (hp[k] != 0) begin
        ph[k]++;
        if (ph[k] >= hp[k]) begin
          ph[k]    = 0;
          mon_v[k] = ~mon_v[k];
        end
      end
    end
    bus.mon_i = mon_v;
  endtask

  task automatic set_mon(input int h0, input int h1);
    hp[0] = h0; hp[1] = h1;
    ph[0] = 0;  ph[1] = 0;
  endtask

  task automatic set_bounds(input int a0, input int b0, input int a1, input int b1);
    mn[0] = a0; mx[0] = b0; mn[1] = a1; mx[1] = b1;
    for (int k = 0; k < nc_lp; k++) begin
      bus.expected_min_i[k*cw_lp +: cw_lp] = cw_lp'(mn[k]);
      bus.expected_max_i[k*cw_lp +: cw_lp] = cw_lp'(mx[k]);
    end
  endtask

  // Rising transitions between consecutive logged samples over [lo, hi].
  function automatic int model_count(input int lo, input int hi, input int k);
    int n = 0;
    for (int m = lo; m <= hi; m++) begin
      if (hist[m][k] === 1'b1 && hist[m-1][k] === 1'b0) n++;
    end
    return n;
  endfunction

  // A report at edge d covers the samples that reached the synchronizer output during its window.
  task automatic check_output(input int d);
    int   n, ec;
    logic eo, ep;
    logic all_exp = 1'b1;
    for (int k = 0; k < nc_lp; k++) begin
      n  = model_count(d - ss_lp - win_lp, d - ss_lp - 1, k);
      ec = (n > cmax_lp) ? cmax_lp : n;
      eo = (n > cmax_lp);
      ep = !eo && (mn[k] <= ec) && (ec <= mx[k]);
      all_exp = all_exp & ep;
      check($sformatf("count_ch%0d", k), 32'(bus.count_o[k*cw_lp +: cw_lp]), 32'(ec));
      check($sformatf("overflow_ch%0d", k), 32'(bus.overflow_o[k]), 32'(eo));
      check($sformatf("pass_ch%0d", k), 32'(bus.pass_o[k]), 32'(ep));
      held_count[k*cw_lp +: cw_lp] = cw_lp'(ec);
    end
    check("all_pass", 32'(bus.all_pass_o), 32'(all_exp));
  endtask

  // Single-shot measurement with ignored start pulses at +10/+40, optional reset at +30.
  task automatic apply_stimulus(input bit tail, input bit rst_mid);
    int e;
    bus.start_i = 1'b1;
    step();
    e = last_edge;
    bus.start_i = 1'b0;
    check("count_hold_on_start", 32'(bus.count_o), 32'(held_count));
    for (int i = 1; i <= lat_lp; i++) begin
      bus.start_i = (i == 10) || (!rst_mid && i == 40);
      reset_i     = rst_mid && (i == 30);
      step();
      if (rst_mid && i == 30) begin
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_count", 32'(bus.count_o), 32'd0);
        check("rst_pass", 32'(bus.pass_o), 32'd0);
        check("rst_overflow", 32'(bus.overflow_o), 32'd0);
        check("rst_all_pass", 32'(bus.all_pass_o), 32'd0);
        held_count = '0;
      end
      check("done", 32'(bus.done_o), 32'((i == lat_lp) && !rst_mid));
    end
    bus.start_i = 1'b0;
    reset_i     = 1'b0;
    if (!rst_mid) begin
      check("busy_at_done", 32'(bus.busy_o), 32'd1);
      check_output(e + lat_lp);
    end
    if (tail) begin
      step();
      check("busy_after_done", 32'(bus.busy_o), 32'd0);
      check("done_after_done", 32'(bus.done_o), 32'd0);
      check("count_held", 32'(bus.count_o), 32'(held_count));
    end
  endtask

  initial begin
    int e;
    bus.start_i        = 1'b0;
    bus.mon_i          = '0;
    bus.expected_min_i = '0;
    bus.expected_max_i = '0;
    set_mon(0, 0);
    set_bounds(0, 0, 0, 0);

    reset_i = 1'b1;
    step();
    step();
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    check("reset_count", 32'(bus.count_o), 32'd0);
    check("reset_overflow", 32'(bus.overflow_o), 32'd0);
    check("reset_pass", 32'(bus.pass_o), 32'd0);
    check("reset_all_pass", 32'(bus.all_pass_o), 32'd0);
    reset_i = 1'b0;
    step();

`ifdef BSG_CLK_GEN_PEARL_FREQ_CHECKER_CONTINUOUS_EN
    $display("[TB] continuous windows");
    set_mon(4, 0);
    set_bounds(7, 9, 1, 5);
    bus.start_i = 1'b1;
    step();
    e = last_edge;
    bus.start_i = 1'b0;
    for (int i = 1; i <= lat_lp + 2*(win_lp + 1) + 2; i++) begin
      step();
      if (i == lat_lp) hp[0] = 8;
      check("cont_busy", 32'(bus.busy_o), 32'd1);
      check("cont_done", 32'(bus.done_o),
            32'(i >= lat_lp && ((i - lat_lp) % (win_lp + 1)) == 0));
      if (i >= lat_lp && ((i - lat_lp) % (win_lp + 1)) == 0) check_output(e + i);
    end
`else
    $display("[TB] nominal");
    set_mon(4, 0);
    set_bounds(7, 9, 1, 5);
    apply_stimulus(1'b1, 1'b0);
    check("nominal_pass", 32'(bus.pass_o), 32'd1);
    check("nominal_all_pass", 32'(bus.all_pass_o), 32'd0);

    $display("[TB] saturation");
    set_mon(2, 4);
    set_bounds(0, 15, 0, 15);
    apply_stimulus(1'b1, 1'b0);
    check("sat_count_ch0", 32'(bus.count_o[cw_lp-1:0]), 32'd15);
    check("sat_overflow_ch0", 32'(bus.overflow_o[0]), 32'd1);
    check("sat_pass_ch0", 32'(bus.pass_o[0]), 32'd0);

    $display("[TB] back-to-back start");
    set_mon(4, 3);
    set_bounds(7, 9, 0, 15);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);

    $display("[TB] range edges");
    set_mon(4, 0);
    set_bounds(8, 8, 0, 0);
    apply_stimulus(1'b1, 1'b0);
    check("exact_range_pass", 32'(bus.pass_o), 32'd3);
    set_bounds(10, 5, 0, 0);
    apply_stimulus(1'b1, 1'b0);
    check("inverted_range_pass_ch0", 32'(bus.pass_o[0]), 32'd0);

    $display("[TB] reset mid-measure");
    set_mon(3, 5);
    set_bounds(0, 15, 0, 15);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0);

    $display("[TB] randomized");
    for (int r = 0; r < 6; r++) begin
      int gap = $urandom_range(0, 4);
      for (int k = 0; k < nc_lp; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          hp[k]    = 0;
          mon_v[k] = 1'($urandom_range(0, 1));
        end else begin
          hp[k] = $urandom_range(2, 7);
        end
        ph[k] = 0;
      end
      bus.mon_i = mon_v;
      set_bounds($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      for (int g = 0; g < gap; g++) step();
      apply_stimulus(1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_clk_gen_pearl_freq_checker.md
Name: bsg_clk_gen_pearl_freq_checker

Overview:
- Testbench-side, synthesizable frequency checker for multi-channel clock-generator pearl boards.
- Samples up to num_channels_p divided monitor outputs (clk_monitor_o class signals) as data in the board reference clock domain.
- Counts rising edges over a programmable window and compares each count against a per-channel [min,max] range.
- Replaces ad-hoc per-channel checks; the PCB harness instantiates one alongside the tag master and gates end-of-test on all_pass_o.

Parameters:
- num_channels_p, 2, number of monitored signals.
- window_cycles_p, 1024, measurement window length in clk_i cycles (>=1).
- count_width_p, 16, per-channel edge counter width.
- sync_stages_p, 2, synchronizer depth on each mon_i bit (>=2).

Ports:
- clk_i  in  1  reference clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin measurement; sampled only in IDLE.
- mon_i  in  num_channels_p  asynchronous monitored signals.
- expected_min_i  in  num_channels_p*count_width_p  per-channel lower bound; channel k at [k*count_width_p +: count_width_p].
- expected_max_i  in  num_channels_p*count_width_p  per-channel upper bound, same packing.
- busy_o  out  1  high in SETTLE/MEASURE/REPORT.
- done_o  out  1  one-cycle pulse in REPORT.
- count_o  out  num_channels_p*count_width_p  last completed counts.
- overflow_o  out  num_channels_p  counter saturated during last window.
- pass_o  out  num_channels_p  per-channel result.
- all_pass_o  out  1  AND of pass_o.

Behaviour:
- Reset: state IDLE; busy_o=0, done_o=0, count_o=0, overflow_o=0, pass_o=0, all_pass_o=0; synchronizer and edge-history flops cleared.
- Per-channel front end: sync_stages_p flop chain, then prev flop; edge = sync_q & ~prev_q.
- States:
  - IDLE: start_i=1 -> SETTLE; internal counters and overflow flags cleared on this transition.
  - SETTLE: exactly sync_stages_p+1 cycles; no counting (flushes stale synchronizer data) -> MEASURE.
  - MEASURE: exactly window_cycles_p cycles; each edge in these cycles increments its channel counter -> REPORT.
  - REPORT: one cycle; done_o=1; internal counts, overflow and pass results transferred to outputs -> IDLE.
- Latency: start_i accepted at cycle t gives done_o at cycle t+sync_stages_p+2+window_cycles_p; outputs valid from that cycle.
- Output hold: outputs hold until the next REPORT; they are not cleared by start_i.
- Window counter width: `BSG_SAFE_CLOG2(window_cycles_p+1).
- Edge counters saturate at 2^count_width_p-1. The first increment attempted at the max value sets that channel's overflow flag; the counter never wraps.
- pass[k] = ~overflow[k] & (min[k] <= count[k]) & (count[k] <= max[k]), unsigned compare. If min>max, pass=0.
- start_i while busy_o=1 is ignored; no queuing.
- reset_i mid-operation forces IDLE in the next cycle with all outputs at their reset values. Reset has priority over start_i.
- mon_i high and low phases must each last at least 2 clk_i periods. Faster signals undercount, and this is not detected (documented limitation).
- expected_min_i and expected_max_i are sampled only in REPORT.

Optional Feature:
- Macro: BSG_CLK_GEN_PEARL_FREQ_CHECKER_CONTINUOUS_EN.
- Defined: after the first start_i, REPORT returns directly to MEASURE (counters cleared, no SETTLE). done_o pulses every window_cycles_p+1 cycles and busy_o stays 1 until reset_i.
- Undefined: single-shot operation; REPORT returns to IDLE and start_i is required for each measurement.

Test Plan:
- Nominal run: num_channels_p=2, window_cycles_p=64, sync_stages_p=2; ch0 toggles every 4 clk_i cycles, ch1 held 0; min/max = 7/9 for ch0 and 1/5 for ch1; start at t -> done_o at t+68; count ch0 in 7..9, pass_o=2'b01, all_pass_o=0, busy_o low at t+69.
- Saturation: count_width_p=4; ch0 toggles every 2 cycles (16 edges in 64) -> count_o ch0=15, overflow_o[0]=1, pass_o[0]=0 even with max=15.
- Start while busy: pulse start_i at t+10 and t+40 after initial start at t -> exactly one done_o at t+68. A new start at t+69 is accepted with done_o at t+137.
- Reset mid-MEASURE: assert reset_i at t+30 -> next cycle busy_o=0, count_o=0, pass_o=0; no done_o. A restart then yields correct counts.
- Range edges: ch0 period 8, expected min=max=measured value -> pass. min=10, max=5 -> pass_o=0.
- Continuous build with the macro defined: single start -> done_o at t+68, t+133, t+198; changing ch0 toggle from every 4 to every 8 cycles is reflected in count_o after the next full window.
